// File: rtl/enc32_5_scan.sv
// Scanning 32-to-5 priority encoder: drains a loaded line vector one index per accepted cycle.
// Optional feature: define ENC_SCAN_COUNT_EN to add the 6-bit popcount output `count`.
module enc32_5_scan (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] in,
   input  logic        ready,
   output logic [4:0]  out,
   output logic        valid,
   output logic        last,
   output logic        busy,
`ifdef ENC_SCAN_COUNT_EN
   output logic [5:0]  count,
`endif
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pending_q, pending_d;
   logic [4:0]  low_idx;
   logic        low_found;
   logic        single;
   logic        load_ok;

   assign load_ok = (state_q == IDLE) && en;

   // Lowest set bit wins: the first hit while walking upward is kept.
   always_comb begin
      low_idx   = '0;
      low_found = 1'b0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (!low_found && pending_q[i]) begin
            low_idx   = 5'(i);
            low_found = 1'b1;
         end
      end
   end

   assign single = (pending_q != '0) && ((pending_q & (pending_q - 32'd1)) == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               pending_d = in;
               state_d   = (in != '0) ? SCAN : DONE;
            end
         end
         SCAN: begin
            if (ready) begin
               pending_d = pending_q & ~(32'd1 << low_idx);
               if (single) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      valid = 1'b0;
      out   = '0;
      last  = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state_q)
         SCAN: begin
            valid = 1'b1;
            out   = low_idx;
            last  = single;
            busy  = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef ENC_SCAN_COUNT_EN
   logic [5:0] count_q;

   function automatic logic [5:0] popcnt(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int unsigned i = 0; i < 32; i++) c = c + 6'(v[i]);
      return c;
   endfunction

   always_ff @(posedge clk) begin
      if (rst)          count_q <= '0;
      else if (load_ok) count_q <= popcnt(in);
   end

   assign count = count_q;
`else
   logic unused_load_ok;
   assign unused_load_ok = load_ok;
`endif

endmodule

// File: tb/tb_enc32_5_scan.sv
// Scoreboard bench for enc32_5_scan: expected indices are queued at load and retired on accept.
// Build with ENC_SCAN_COUNT_EN defined to also check the popcount output.
module tb_enc32_5_scan;

   typedef struct packed {
      logic [4:0] idx;
      logic       last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, en, ready;
   logic [31:0] in;
   logic [4:0]  out;
   logic        valid, last, busy, done;
`ifdef ENC_SCAN_COUNT_EN
   logic [5:0]  count;
`endif

   exp_t        exp_q[$];
   logic        pat_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic        exp_done_next = 1'b0;
   logic        loading   = 1'b0;
   logic        zero_load = 1'b0;
   logic        rnd_ready = 1'b0;
   logic [5:0]  exp_cnt   = '0;
   int          ncyc;

   enc32_5_scan dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .in    (in),
      .ready (ready),
      .out   (out),
      .valid (valid),
      .last  (last),
      .busy  (busy),
`ifdef ENC_SCAN_COUNT_EN
      .count (count),
`endif
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: compare at the falling edge, then advance past the rising edge.
   task automatic step();
      logic exp_valid, exp_done_now, nxt_done;
      @(negedge clk);
      exp_valid    = (exp_q.size() > 0) && !loading;
      exp_done_now = exp_done_next;
      check("valid", valid, exp_valid);
      check("done", done, exp_done_now);
      check("busy", busy, exp_valid || exp_done_now);
      nxt_done = zero_load;
      if (exp_valid) begin
         check("out", out, exp_q[0].idx);
         check("last", last, exp_q[0].last);
         if (ready) begin
            nxt_done = exp_q[0].last;
            void'(exp_q.pop_front());
         end
      end else begin
         check("out_idle", out, 0);
         check("last_idle", last, 0);
      end
      exp_done_next = nxt_done;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      exp_done_next = 1'b0;
      exp_cnt = '0;
      check("rst_out", out, 0);
      check("rst_valid", valid, 0);
      check("rst_last", last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
`ifdef ENC_SCAN_COUNT_EN
      check("rst_count", count, 0);
`endif
   endtask

   task automatic load(input logic [31:0] v);
      int pop, k;
      exp_t e;
      pop = 0;
      for (int i = 0; i < 32; i++) if (v[i]) pop++;
      k = 0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) begin
            e.idx  = 5'(i);
            e.last = (k == pop - 1);
            exp_q.push_back(e);
            k++;
         end
      end
      exp_cnt   = 6'(pop);
      en        = 1'b1;
      in        = v;
      loading   = 1'b1;
      zero_load = (v == '0);
      step();
      loading   = 1'b0;
      zero_load = 1'b0;
      en        = 1'b0;
      in        = '0;
   endtask

   // Runs until the scoreboard empties, then covers the done cycle and the return to idle.
   task automatic drain(input int budget, output int n);
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         if (pat_q.size() > 0) ready = pat_q.pop_front();
         else if (rnd_ready)   ready = ($urandom_range(0, 3) != 0);
         else                  ready = 1'b1;
         step();
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
`ifdef ENC_SCAN_COUNT_EN
      check("count", count, exp_cnt);
`endif
      step();
      step();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; in = '0; ready = 1'b0;
      do_reset(2);
      step();

      load(32'h0000_0012);
      drain(100, ncyc);
      check("cyc_12", ncyc, 2);

      load(32'hFFFF_FFFF);
      drain(100, ncyc);
      check("cyc_ffff", ncyc, 32);

      load(32'h0000_0000);
      drain(100, ncyc);
      check("cyc_zero", ncyc, 0);

      load(32'h8000_0000);
      drain(100, ncyc);

      pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      load(32'h8000_0401);
      drain(100, ncyc);
      check("cyc_hold", ncyc, 5);

      load(32'h0000_00F0);
      ready = 1'b1;
      step();
      ready = 1'b0;
      step();
      do_reset(1);
      step();
      load(32'h0000_0001);
      drain(100, ncyc);

      load(32'h0000_000C);
      ready = 1'b0;
      en = 1'b1;
      in = 32'h0000_0003;
      step();
      en = 1'b0;
      in = '0;
      drain(100, ncyc);

      rnd_ready = 1'b1;
      for (int t = 0; t < 8; t++) begin
         load($urandom() & $urandom());
         drain(400, ncyc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
